parking_flow_decoder: RTL and testbench
=======================================

# parking_flow_decoder

Consumes the two debounced beam-sensor levels produced by the input debouncers at the parking gate and decodes their sequence into vehicle entry and exit events. Maintains the occupancy count against a fixed capacity and drives full/empty flags plus single-cycle event pulses for the display and barrier logic downstream.

## Interface
- CAPACITY, 15, maximum occupancy; legal range 1 to 2**WIDTH-1
- WIDTH, 4, width of the occupancy count
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- sensor_a  in  1  debounced outer beam, 1 = blocked; already synchronous to clk
- sensor_b  in  1  debounced inner beam, 1 = blocked; already synchronous to clk
- entry_pulse  out  1  one-cycle pulse per accepted entry
- exit_pulse  out  1  one-cycle pulse per accepted exit
- error_pulse  out  1  one-cycle pulse on illegal sensor sequence, overflow or underflow
- count  out  WIDTH  current occupancy
- full  out  1  count == CAPACITY
- empty  out  1  count == 0

## Operation
- Reset is synchronous and active-low: state = IDLE, count = 0, all pulses 0, empty = 1, full = 0. Reset mid-sequence discards the partial sequence with no pulse.
- No internal synchronizer or filter; sensor inputs are used as registered levels from the debouncers.
- Sensor pair notation {a,b}. FSM states: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A.
- IDLE: 10 -> IN_A; 01 -> OUT_B; 11 -> IDLE with error_pulse; 00 -> stay.
- IN_A: 10 stay; 11 -> IN_AB; 00 -> IDLE with no pulse (aborted); 01 -> IDLE with error_pulse.
- IN_AB: 11 stay; 01 -> IN_B; 10 -> IN_A (backing out); 00 -> IDLE with error_pulse.
- IN_B: 01 stay; 11 -> IN_AB; 00 -> IDLE with an entry event; 10 -> IDLE with error_pulse.
- OUT_B, OUT_AB and OUT_A mirror IN_A, IN_AB and IN_B with a and b swapped. OUT_A followed by 00 produces an exit event.
- Entry event:
  - If count < CAPACITY: count += 1 and entry_pulse.
  - Otherwise count holds and error_pulse fires (overflow); no entry_pulse.
- Exit event:
  - If count > 0: count -= 1 and exit_pulse.
  - Otherwise count holds and error_pulse fires (underflow).
- Arithmetic is never modulo; count never wraps.
- At most one of entry_pulse, exit_pulse or error_pulse is asserted in any cycle.
- full and empty decode combinationally from the count register.

## Timing
- Inputs are sampled at clock edge k. State, count and pulses update at edge k and are visible during cycle k+1. Latency from the final 00 sample to the pulse is 1 cycle.
- Each pulse lasts exactly 1 cycle, even if the sensors stay at 00.
- count, full and empty change in the same cycle as the corresponding pulse.
- Minimum legal entry is 4 samples (10, 11, 01, 00) giving the pulse 1 cycle after the 00 sample. Dwell in any state is unbounded; there is no timeout.
- Reset has priority over all events at the same edge.

## Test plan
- Reset with rst_n = 0 for 2 cycles while the sensors are 11 -> state IDLE, count 0, empty 1, full 0, no pulses; release with the sensors at 00 -> still no pulses.
- Entry sequence 10, 11, 01, 00, each level held 3 cycles -> single entry_pulse 1 cycle after the first 00 sample, count goes 0 to 1, empty drops in the same cycle. Exit sequence 01, 11, 10, 00 -> single exit_pulse, count returns to 0.
- Aborted and backing sequences:
  - 10, 00 -> no pulse, count unchanged.
  - 10, 11, 10, 11, 01, 00 -> exactly one entry_pulse.
  - 10, 11, 01, 11, 01, 00 -> exactly one entry_pulse.
- Illegal sequences each give one error_pulse, return to IDLE and leave count unchanged:
  - 11 from IDLE.
  - 10 followed by 01.
  - 10, 11, 00.
- With CAPACITY = 3: 3 entries -> count 3, full 1. A 4th entry -> error_pulse only, count stays 3. From count 0, one exit -> error_pulse, count stays 0, empty stays 1.
- Assert rst_n = 0 while the FSM is in IN_B with count = 2 -> count 0, state IDLE, no entry_pulse. Releasing reset with the sensors at 00 -> no pulse.

Source files
------------

// File: rtl/parking_flow_decoder.sv
// Decodes the outer/inner beam sequence at the parking gate into entry and exit
// events and tracks occupancy against a fixed capacity.
module parking_flow_decoder #(
    parameter int CAPACITY = 15,
    parameter int WIDTH    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor_a,
    input  logic             sensor_b,
    output logic             entry_pulse,
    output logic             exit_pulse,
    output logic             error_pulse,
    output logic [WIDTH-1:0] count,
    output logic             full,
    output logic             empty
);

    typedef enum logic [2:0] {
        IDLE,
        IN_A,
        IN_AB,
        IN_B,
        OUT_B,
        OUT_AB,
        OUT_A
    } state_t;

    localparam logic [WIDTH-1:0] CAP = WIDTH'(CAPACITY);

    state_t           state_reg;
    logic [WIDTH-1:0] count_reg;
    logic             entry_reg;
    logic             exit_reg;
    logic             error_reg;
    logic [1:0]       ab;

    assign ab = {sensor_a, sensor_b};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            entry_reg <= 1'b0;
            exit_reg  <= 1'b0;
            error_reg <= 1'b0;
        end else begin
            entry_reg <= 1'b0;
            exit_reg  <= 1'b0;
            error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    case (ab)
                        2'b10:   state_reg <= IN_A;
                        2'b01:   state_reg <= OUT_B;
                        2'b11:   error_reg <= 1'b1;
                        default: state_reg <= IDLE;
                    endcase
                end
                IN_A: begin
                    case (ab)
                        2'b11:   state_reg <= IN_AB;
                        2'b00:   state_reg <= IDLE;
                        2'b01: begin
                            state_reg <= IDLE;
                            error_reg <= 1'b1;
                        end
                        default: state_reg <= IN_A;
                    endcase
                end
                IN_AB: begin
                    case (ab)
                        2'b01:   state_reg <= IN_B;
                        2'b10:   state_reg <= IN_A;
                        2'b00: begin
                            state_reg <= IDLE;
                            error_reg <= 1'b1;
                        end
                        default: state_reg <= IN_AB;
                    endcase
                end
                IN_B: begin
                    case (ab)
                        2'b11:   state_reg <= IN_AB;
                        2'b00: begin
                            // Vehicle cleared the inner beam: entry completes here
                            state_reg <= IDLE;
                            if (count_reg < CAP) begin
                                count_reg <= count_reg + WIDTH'(1);
                                entry_reg <= 1'b1;
                            end else begin
                                error_reg <= 1'b1;
                            end
                        end
                        2'b10: begin
                            state_reg <= IDLE;
                            error_reg <= 1'b1;
                        end
                        default: state_reg <= IN_B;
                    endcase
                end
                OUT_B: begin
                    case (ab)
                        2'b11:   state_reg <= OUT_AB;
                        2'b00:   state_reg <= IDLE;
                        2'b10: begin
                            state_reg <= IDLE;
                            error_reg <= 1'b1;
                        end
                        default: state_reg <= OUT_B;
                    endcase
                end
                OUT_AB: begin
                    case (ab)
                        2'b10:   state_reg <= OUT_A;
                        2'b01:   state_reg <= OUT_B;
                        2'b00: begin
                            state_reg <= IDLE;
                            error_reg <= 1'b1;
                        end
                        default: state_reg <= OUT_AB;
                    endcase
                end
                OUT_A: begin
                    case (ab)
                        2'b11:   state_reg <= OUT_AB;
                        2'b00: begin
                            state_reg <= IDLE;
                            if (count_reg != '0) begin
                                count_reg <= count_reg - WIDTH'(1);
                                exit_reg  <= 1'b1;
                            end else begin
                                error_reg <= 1'b1;
                            end
                        end
                        2'b01: begin
                            state_reg <= IDLE;
                            error_reg <= 1'b1;
                        end
                        default: state_reg <= OUT_A;
                    endcase
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign entry_pulse = entry_reg;
    assign exit_pulse  = exit_reg;
    assign error_pulse = error_reg;
    assign count       = count_reg;
    assign full        = (count_reg == CAP);
    assign empty       = (count_reg == '0);

endmodule

// File: tb/tb_parking_flow_decoder.sv
// Directed bench: stimulus pushes expected pulses into a scoreboard queue and a
// negedge monitor pops and compares each pulse the decoder produces.
module tb_parking_flow_decoder;

    localparam int CAP = 3;
    localparam int W   = 4;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_ENT  = 2'd1;
    localparam logic [1:0] K_EXT  = 2'd2;
    localparam logic [1:0] K_ERR  = 2'd3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sensor_a;
    logic         sensor_b;
    logic         entry_pulse;
    logic         exit_pulse;
    logic         error_pulse;
    logic [W-1:0] count;
    logic         full;
    logic         empty;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [1:0]   kind;
        logic [W-1:0] cnt;
        int           cyc;
    } exp_t;

    exp_t sb[$];

    parking_flow_decoder #(.CAPACITY(CAP), .WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sensor_a   (sensor_a),
        .sensor_b   (sensor_b),
        .entry_pulse(entry_pulse),
        .exit_pulse (exit_pulse),
        .error_pulse(error_pulse),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest pending expectation exactly
    always @(negedge clk) begin
        logic [1:0] kind;
        exp_t       e;
        kind = entry_pulse ? K_ENT : exit_pulse ? K_EXT : error_pulse ? K_ERR : K_NONE;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_pulse: kind %0d expected at cycle %0d did not occur", e.kind, e.cyc);
        end
        if (kind != K_NONE) begin
            chk("one_hot_pulse", int'(entry_pulse) + int'(exit_pulse) + int'(error_pulse), 1);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: kind %0d count %0d at cycle %0d", kind, count, cyc);
            end else begin
                e = sb.pop_front();
                $display("pulse kind=%0d count=%0d cycle=%0d (exp kind=%0d count=%0d cycle=%0d)",
                         kind, count, cyc, e.kind, e.cnt, e.cyc);
                chk("pulse_kind", int'(kind), int'(e.kind));
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_count", int'(count), int'(e.cnt));
                chk("pulse_full", int'(full), int'(e.cnt == W'(CAP)));
                chk("pulse_empty", int'(empty), int'(e.cnt == '0));
            end
        end
    end

    // Called at a negedge: drive a level, register any expected pulse, hold
    task automatic step(input logic [1:0] ab, input int hold,
                        input logic [1:0] kind, input logic [W-1:0] cnt);
        exp_t e;
        sensor_a = ab[1];
        sensor_b = ab[0];
        if (kind != K_NONE) begin
            e.kind = kind;
            e.cnt  = cnt;
            e.cyc  = cyc + 1;
            sb.push_back(e);
        end
        repeat (hold) @(negedge clk);
    endtask

    task automatic entry(input logic [1:0] kind, input logic [W-1:0] cnt);
        step(2'b10, 3, K_NONE, '0);
        step(2'b11, 3, K_NONE, '0);
        step(2'b01, 3, K_NONE, '0);
        step(2'b00, 3, kind, cnt);
    endtask

    task automatic leave(input logic [1:0] kind, input logic [W-1:0] cnt);
        step(2'b01, 3, K_NONE, '0);
        step(2'b11, 3, K_NONE, '0);
        step(2'b10, 3, K_NONE, '0);
        step(2'b00, 3, kind, cnt);
    endtask

    initial begin
        rst_n    = 1'b0;
        sensor_a = 1'b1;
        sensor_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_count", int'(count), 0);
        chk("reset_empty", int'(empty), 1);
        chk("reset_full", int'(full), 0);
        chk("reset_pulses", int'({entry_pulse, exit_pulse, error_pulse}), 0);
        rst_n = 1'b1;
        step(2'b00, 3, K_NONE, '0);
        chk("post_reset_count", int'(count), 0);

        entry(K_ENT, 4'd1);
        leave(K_EXT, 4'd0);

        // Aborted approach
        step(2'b10, 3, K_NONE, '0);
        step(2'b00, 3, K_NONE, '0);
        chk("abort_count", int'(count), 0);

        // Backing out to IN_A then completing
        step(2'b10, 3, K_NONE, '0);
        step(2'b11, 3, K_NONE, '0);
        step(2'b10, 3, K_NONE, '0);
        step(2'b11, 3, K_NONE, '0);
        step(2'b01, 3, K_NONE, '0);
        step(2'b00, 3, K_ENT, 4'd1);

        // Bouncing between IN_B and IN_AB then completing
        step(2'b10, 3, K_NONE, '0);
        step(2'b11, 3, K_NONE, '0);
        step(2'b01, 3, K_NONE, '0);
        step(2'b11, 3, K_NONE, '0);
        step(2'b01, 3, K_NONE, '0);
        step(2'b00, 3, K_ENT, 4'd2);

        // Illegal sequences
        step(2'b11, 1, K_ERR, 4'd2);
        step(2'b00, 3, K_NONE, '0);
        step(2'b10, 3, K_NONE, '0);
        step(2'b01, 3, K_ERR, 4'd2);
        step(2'b00, 3, K_NONE, '0);
        step(2'b10, 3, K_NONE, '0);
        step(2'b11, 3, K_NONE, '0);
        step(2'b00, 3, K_ERR, 4'd2);
        chk("illegal_count", int'(count), 2);

        // Fill to capacity, overflow, drain, underflow
        entry(K_ENT, 4'd3);
        chk("cap_full", int'(full), 1);
        entry(K_ERR, 4'd3);
        chk("overflow_count", int'(count), 3);
        leave(K_EXT, 4'd2);
        leave(K_EXT, 4'd1);
        leave(K_EXT, 4'd0);
        leave(K_ERR, 4'd0);
        chk("underflow_count", int'(count), 0);
        chk("underflow_empty", int'(empty), 1);

        // Reset while parked in IN_B with count 2
        entry(K_ENT, 4'd1);
        entry(K_ENT, 4'd2);
        step(2'b10, 3, K_NONE, '0);
        step(2'b11, 3, K_NONE, '0);
        step(2'b01, 3, K_NONE, '0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        @(negedge clk);
        chk("midseq_reset_count", int'(count), 0);
        chk("midseq_reset_empty", int'(empty), 1);
        rst_n = 1'b1;
        step(2'b00, 5, K_NONE, '0);
        chk("post_release_count", int'(count), 0);
        chk("pending_expectations", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
